// File: rtl/mult_pkg.sv
// Shared widths, types and the final partial-product summation for the Vedic multiplier tree.
package mult_pkg;

    localparam int unsigned OPW   = 32;
    localparam int unsigned PRODW = 64;
    localparam int unsigned HALFW = 16;

    typedef logic [OPW-1:0]   operand_t;
    typedef logic [PRODW-1:0] product_t;
    typedef logic [HALFW-1:0] half_t;

    // q1+q2 keeps its carry at 33 bits before the shift so the full-range product stays exact
    function automatic product_t sum_pp(input operand_t q0, input operand_t q1,
                                        input operand_t q2, input operand_t q3);
        logic [OPW:0] mid;
        mid = {1'b0, q1} + {1'b0, q2};
        return {32'b0, q0} + {15'b0, mid, 16'b0} + {q3, 32'b0};
    endfunction

endpackage

// File: rtl/mult_32bit_if.sv
// Operand/product bus of the 32x32 multiplier; master drives operands, slave returns the product.
interface mult_32bit_if;
    import mult_pkg::*;

    logic     in_valid;
    operand_t a;
    operand_t b;
    product_t c;
    logic     out_valid;

    modport master (output in_valid, output a, output b, input c, input out_valid);
    modport slave  (input in_valid, input a, input b, output c, output out_valid);

endinterface

// File: rtl/mult_16bit.sv
// Combinational 16x16 -> 32 Vedic multiplier built from four 8x8 partial products.
module mult_16bit
    import mult_pkg::*;
(
    input  half_t          a,
    input  half_t          b,
    output logic [OPW-1:0] p
);

    logic [7:0]  al, ah, bl, bh;
    logic [15:0] p0, p1, p2, p3;
    logic [16:0] mid;

    always_comb begin
        al  = a[7:0];
        ah  = a[15:8];
        bl  = b[7:0];
        bh  = b[15:8];
        p0  = {8'b0, al} * {8'b0, bl};
        p1  = {8'b0, ah} * {8'b0, bl};
        p2  = {8'b0, al} * {8'b0, bh};
        p3  = {8'b0, ah} * {8'b0, bh};
        mid = {1'b0, p1} + {1'b0, p2};
        p   = {16'b0, p0} + {7'b0, mid, 8'b0} + {p3, 16'b0};
    end

endmodule

// File: rtl/mult_32bit.sv
// Unsigned 32x32 -> 64 Vedic multiplier with registered product and valid strobe.
// Define MULT_32BIT_PIPE_EN to register the partial products (latency 2 instead of 1).
module mult_32bit
    import mult_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mult_32bit_if.slave  bus
);

    operand_t q0, q1, q2, q3;
    product_t c_r;
    logic     out_valid_r;

    mult_16bit u_q0 (.a(bus.a[15:0]),  .b(bus.b[15:0]),  .p(q0));
    mult_16bit u_q1 (.a(bus.a[31:16]), .b(bus.b[15:0]),  .p(q1));
    mult_16bit u_q2 (.a(bus.a[15:0]),  .b(bus.b[31:16]), .p(q2));
    mult_16bit u_q3 (.a(bus.a[31:16]), .b(bus.b[31:16]), .p(q3));

`ifdef MULT_32BIT_PIPE_EN
    operand_t q0_r, q1_r, q2_r, q3_r;
    logic     v1;

    always_ff @(posedge clk) begin
        if (rst) begin
            q0_r <= '0;
            q1_r <= '0;
            q2_r <= '0;
            q3_r <= '0;
            v1   <= 1'b0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                q0_r <= q0;
                q1_r <= q1;
                q2_r <= q2;
                q3_r <= q3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_r         <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= v1;
            if (v1) c_r <= sum_pp(q0_r, q1_r, q2_r, q3_r);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            c_r         <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) c_r <= sum_pp(q0, q1, q2, q3);
        end
    end
`endif

    assign bus.c         = c_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mult_32bit.sv
// Scoreboard bench for mult_32bit: expected products queued at drive time, popped on out_valid.
module tb_mult_32bit;
    import mult_pkg::*;

`ifdef MULT_32BIT_PIPE_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_32bit_if ifc ();

    mult_32bit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    product_t       sb[$];
    logic [LAT-1:0] vline;
    product_t       last_c;
    product_t       exp_c;
    int             checks   = 0;
    int             failures = 0;

    task automatic check_outputs();
        checks++;
        assert (ifc.out_valid === vline[LAT-1])
        else begin
            failures++;
            $error("FAIL out_valid observed=%b expected=%b", ifc.out_valid, vline[LAT-1]);
        end
        if (vline[LAT-1]) begin
            checks++;
            assert (sb.size() > 0)
            else begin
                failures++;
                $error("FAIL sb_underflow observed_c=%h expected=queued_entry", ifc.c);
            end
            if (sb.size() > 0) begin
                exp_c  = sb.pop_front();
                last_c = exp_c;
                checks++;
                assert (ifc.c === exp_c)
                else begin
                    failures++;
                    $error("FAIL product observed=%h expected=%h", ifc.c, exp_c);
                end
            end
        end else begin
            checks++;
            assert (ifc.c === last_c)
            else begin
                failures++;
                $error("FAIL hold_c observed=%h expected=%h", ifc.c, last_c);
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input operand_t x, input operand_t y,
                        input product_t e);
        rst          = r;
        ifc.in_valid = v;
        ifc.a        = x;
        ifc.b        = y;
        if (r) begin
            vline  = '0;
            last_c = '0;
            sb.delete();
        end else begin
            vline = {vline, v};
            if (v) sb.push_back(e);
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic product_t ref_mul(input operand_t x, input operand_t y);
        return {32'b0, x} * {32'b0, y};
    endfunction

    initial begin
        operand_t ra, rb;
        vline  = '0;
        last_c = '0;

        step(1'b1, 1'b1, 32'd5, 32'd7, '0);
        step(1'b1, 1'b1, 32'd5, 32'd7, '0);

        step(1'b0, 1'b1, 32'h0, 32'h0, 64'h0);
        step(1'b0, 1'b1, 32'h1, 32'hDEADBEEF, 64'h00000000DEADBEEF);
        step(1'b0, 1'b1, 32'h00010000, 32'h00010000, 64'h0000000100000000);
        step(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        step(1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, '0);
        step(1'b0, 1'b0, 32'h0, 32'h0, '0);
        step(1'b0, 1'b0, 32'h0, 32'h0, '0);

        for (int n = 0; n < 40; n++)
            step(1'b0, 1'b1, operand_t'(n / 2), operand_t'(n),
                 ref_mul(operand_t'(n / 2), operand_t'(n)));

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            if (i % 97 == 0) ra = 32'hFFFFFFFF;
            step(1'b0, 1'b1, ra, rb, ref_mul(ra, rb));
        end

        step(1'b0, 1'b1, 32'hCAFEBABE, 32'h0BADF00D, ref_mul(32'hCAFEBABE, 32'h0BADF00D));
        step(1'b1, 1'b1, 32'h11111111, 32'h22222222, '0);
        step(1'b0, 1'b0, 32'h0, 32'h0, '0);
        step(1'b0, 1'b0, 32'h0, 32'h0, '0);
        step(1'b0, 1'b1, 32'h00000003, 32'h00000005, 64'd15);
        step(1'b0, 1'b1, 32'h80000000, 32'h00000002, 64'h0000000100000000);
        step(1'b0, 1'b0, 32'h0, 32'h0, '0);
        step(1'b0, 1'b0, 32'h0, 32'h0, '0);

        checks++;
        assert (sb.size() == 0)
        else begin
            failures++;
            $error("FAIL drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
